// File: rtl/cpu_pkg.sv
// cpu_pkg: ALU control codes shared by the ALU, the ALU control and the multiply sequencer, plus the sequencer state type
package cpu_pkg;
  localparam logic [2:0] AND = 3'b000;
  localparam logic [2:0] OR  = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] MUL = 3'b011;
  localparam logic [2:0] SUB = 3'b110;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;
endpackage

// File: rtl/mul_shift_add_dp.sv
// mul_shift_add_dp: radix-2 shift-add datapath, one multiplier bit consumed per step
module mul_shift_add_dp #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplr_in,
  output logic [WIDTH-1:0] acc
);
  logic [WIDTH-1:0] mcand, mplr;
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
    end else if (load) begin
      mcand <= mcand_in;
      mplr  <= mplr_in;
      acc   <= '0;
    end else if (step) begin
      acc   <= mplr[0] ? acc + mcand : acc;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
    end
  end
endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle EX-stage MUL controller; stalls the pipeline while the shift-add datapath iterates
module mul_sequencer import cpu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);
  mul_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic             accept;
  // accept-cycle stall is combinational so ID/EX keeps the MUL while it is captured
  always_comb begin
    accept   = rst_i && !flush_i && start_i && ALUCtrl_i == MUL && state == IDLE;
    stall_o  = accept || (rst_i && state == BUSY);
    done_o   = rst_i && !flush_i && state == DONE;
    result_o = done_o ? acc : '0;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state <= BUSY;
          cnt   <= CNT_W'(WIDTH - 1);
        end
        BUSY: if (flush_i) state <= IDLE;
              else if (cnt == '0) state <= DONE;
              else cnt <= cnt - CNT_W'(1);
        default: state <= IDLE;
      endcase
    end
  end
  mul_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (accept),
    .step     (state == BUSY),
    .mcand_in (data1_i),
    .mplr_in  (data2_i),
    .acc      (acc)
  );
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: randomized and directed checks of the MUL sequencer against a plain-arithmetic product/latency model
module tb_mul_sequencer;
  localparam int W = 32;
  localparam int LAT = W + 1;
  logic clk = 0;
  logic rst_i, start_i, flush_i;
  logic [2:0] ALUCtrl_i;
  logic [W-1:0] data1_i, data2_i;
  logic stall_o, done_o;
  logic [W-1:0] result_o;
  int vectors = 0, miscompares = 0;

  mul_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .ALUCtrl_i(ALUCtrl_i),
    .data1_i(data1_i), .data2_i(data2_i), .flush_i(flush_i),
    .stall_o(stall_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return p[W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one MUL from its accept cycle and returns what was observed; ends in the cycle after done
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input int chg,
                         output int stalls, output int lat, output logic [W-1:0] res);
    stalls = 0; lat = -1; res = 'x;
    start_i = 1; ALUCtrl_i = 3'b011; data1_i = a; data2_i = b;
    for (int c = 0; c < 3 * W && lat < 0; c++) begin
      if (c == chg) data1_i = '0;
      #1;
      if (stall_o) stalls++;
      if (done_o) begin lat = c; res = result_o; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_i = 0; start_i = 1; ALUCtrl_i = 3'b011; data1_i = 5; data2_i = 5; flush_i = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({stall_o, done_o, result_o} !== {2'b00, {W{1'b0}}}) begin
        miscompares++;
        $display("FAIL reset: stall=%b done=%b result=%h, expected 0/0/0", stall_o, done_o, result_o);
      end
    end
    rst_i = 1; start_i = 0;
    tick();
  endtask

  task automatic test_basic();
    int s, l;
    logic [W-1:0] r;
    run_mul(7, 6, -1, s, l, r);
    vectors++;
    if (s !== LAT) begin miscompares++; $display("FAIL basic_stall: %0d cycles, expected %0d", s, LAT); end
    vectors++;
    if (l !== LAT) begin miscompares++; $display("FAIL basic_latency: done at %0d, expected %0d", l, LAT); end
    vectors++;
    if (r !== 42) begin miscompares++; $display("FAIL basic_result: %0d, expected 42", r); end
    start_i = 0;
    #1;
    vectors++;
    if ({stall_o, done_o, result_o} !== {2'b00, {W{1'b0}}}) begin
      miscompares++;
      $display("FAIL basic_idle: stall=%b done=%b result=%h, expected 0/0/0", stall_o, done_o, result_o);
    end
    tick();
  endtask

  task automatic test_corners();
    logic [W-1:0] ops [3] = '{32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_0000};
    int s, l;
    logic [W-1:0] r;
    for (int i = 0; i < 3; i++) begin
      run_mul(ops[i], ops[i] ^ {W{i == 2}}, -1, s, l, r);
      start_i = 0;
      vectors++;
      if (r !== model(ops[i], ops[i] ^ {W{i == 2}}) || l !== LAT || s !== LAT) begin
        miscompares++;
        $display("FAIL corner%0d: result=%h lat=%0d stall=%0d, expected %h/%0d/%0d",
                 i, r, l, s, model(ops[i], ops[i] ^ {W{i == 2}}), LAT, LAT);
      end
      tick();
    end
  endtask

  task automatic test_non_mul();
    logic [2:0] codes [4] = '{3'b000, 3'b001, 3'b010, 3'b110};
    for (int i = 0; i < 4; i++) begin
      start_i = 1; ALUCtrl_i = codes[i]; data1_i = $urandom; data2_i = $urandom;
      for (int c = 0; c < 3; c++) begin
        #1;
        vectors++;
        if (stall_o !== 0 || done_o !== 0) begin
          miscompares++;
          $display("FAIL non_mul code=%b cycle=%0d: stall=%b done=%b, expected 0/0", codes[i], c, stall_o, done_o);
        end
        tick();
      end
    end
    start_i = 0;
  endtask

  task automatic test_back_to_back();
    int s1, l1, s2, l2;
    logic [W-1:0] r1, r2;
    run_mul(3, 5, -1, s1, l1, r1);
    run_mul(32'h8000_0000, 2, -1, s2, l2, r2);
    start_i = 0;
    vectors++;
    if (l1 + 1 !== 34 || l1 + 2 + l2 !== 68) begin
      miscompares++;
      $display("FAIL b2b_timing: done at %0d and %0d, expected 34 and 68", l1 + 1, l1 + 2 + l2);
    end
    vectors++;
    if (r1 !== 15 || r2 !== 0) begin
      miscompares++;
      $display("FAIL b2b_result: %0d and %0d, expected 15 and 0", r1, r2);
    end
    tick();
  endtask

  task automatic test_random();
    int s, l;
    logic [W-1:0] a, b, r;
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom;
      if (i == 0) b = '1;
      run_mul(a, b, -1, s, l, r);
      start_i = 0;
      vectors++;
      if (r !== model(a, b) || l !== LAT || s !== LAT) begin
        miscompares++;
        $display("FAIL random %h*%h: result=%h lat=%0d stall=%0d, expected %h/%0d/%0d",
                 a, b, r, l, s, model(a, b), LAT, LAT);
      end
      tick();
    end
  endtask

  // Aborts a 100x100 at BUSY cycle 10 by reset (use_rst) or flush, then proves a fresh MUL still works
  task automatic test_abort(input bit use_rst);
    int s, l, dones;
    logic [W-1:0] a, b, r;
    start_i = 1; ALUCtrl_i = 3'b011; data1_i = 100; data2_i = 100;
    for (int c = 0; c < 10; c++) tick();
    start_i = 0;
    if (use_rst) rst_i = 0; else flush_i = 1;
    #1;
    vectors++;
    if (done_o !== 0 || (use_rst && stall_o !== 0)) begin
      miscompares++;
      $display("FAIL abort%0d_cycle: stall=%b done=%b", use_rst, stall_o, done_o);
    end
    tick();
    rst_i = 1; flush_i = 0;
    #1;
    vectors++;
    if ({stall_o, done_o, result_o} !== {2'b00, {W{1'b0}}}) begin
      miscompares++;
      $display("FAIL abort%0d_next: stall=%b done=%b result=%h, expected 0/0/0", use_rst, stall_o, done_o, result_o);
    end
    dones = 0;
    for (int c = 0; c < W + 8; c++) begin
      #1;
      dones += int'(done_o) + int'(stall_o);
      tick();
    end
    vectors++;
    if (dones !== 0) begin miscompares++; $display("FAIL abort%0d_quiet: %0d active cycles, expected 0", use_rst, dones); end
    a = $urandom; b = $urandom;
    run_mul(a, b, -1, s, l, r);
    start_i = 0;
    vectors++;
    if (r !== model(a, b) || l !== LAT) begin
      miscompares++;
      $display("FAIL abort%0d_fresh: result=%h lat=%0d, expected %h/%0d", use_rst, r, l, model(a, b), LAT);
    end
    tick();
  endtask

  task automatic test_idle_flush();
    start_i = 1; ALUCtrl_i = 3'b011; data1_i = 3; data2_i = 3; flush_i = 1;
    #1;
    vectors++;
    if (stall_o !== 0 || done_o !== 0) begin
      miscompares++;
      $display("FAIL idle_flush: stall=%b done=%b, expected 0/0", stall_o, done_o);
    end
    tick();
    start_i = 0; flush_i = 0;
    #1;
    vectors++;
    if (stall_o !== 0) begin miscompares++; $display("FAIL idle_flush_next: stall=%b, expected 0", stall_o); end
    tick();
  endtask

  task automatic test_operand_change();
    int s, l;
    logic [W-1:0] r;
    run_mul(9, 9, 5, s, l, r);
    start_i = 0;
    vectors++;
    if (r !== 81 || l !== LAT) begin
      miscompares++;
      $display("FAIL operand_change: result=%0d lat=%0d, expected 81/%0d", r, l, LAT);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_non_mul();
    test_back_to_back();
    test_random();
    test_abort(1);
    test_abort(0);
    test_idle_flush();
    test_operand_change();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
